// File: rtl/systolic_pkg.sv
// Package: systolic_pkg
// Shared defaults and types for the systolic-array result readback path.
//   DATA_W        width of one signed result element
//   N             array dimension; a tile holds N*N elements
//   ADDR_W        width of the result-memory write address
//   drain_state_e readback FSM states (IDLE, DRAIN)
//   elem_t        one signed result element
package systolic_pkg;

    localparam int DATA_W = 16;
    localparam int N      = 4;
    localparam int ADDR_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef logic signed [DATA_W-1:0] elem_t;

endpackage

// File: rtl/result_drain_streamer.sv
// Module: result_drain_streamer
// Reads the NxN result tile out of the systolic array once the array
// controller signals done. The whole tile and the base address are captured
// in one cycle. The N*N values are then streamed row-major over a
// valid/ready port, each paired with its write address.
//
// Handshake: a transfer happens on any clock edge where out_valid_o and
// out_ready_i are both high. Once out_valid_o rises, it stays high, and
// out_data_o and out_addr_o stay stable, until that transfer happens.
// The consumer may hold out_ready_i low for as long as it likes.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   done_i         array-controller done (level or pulse)
//   r_flat_i       tile, element (i,j) at [DATA_W*(N*i+j) +: DATA_W]
//   base_addr_i    first output address, captured with the tile
//   out_valid_o    element available
//   out_ready_i    consumer accepts
//   out_data_o     current element (signed)
//   out_addr_o     base + index, wrapping mod 2**ADDR_W
//   busy_o         high while draining; this is the FSM state bit
//   drain_done_o   one-cycle pulse after the final transfer
//   overrun_o      sticky: a done_i arrived mid-drain and was dropped
//   overrun_clr_i  clears overrun_o; a new overrun in the same cycle wins
//
// Build option RESULT_DRAIN_LAST_EN adds:
//   out_last_o     high with out_valid_o on the last element of the tile
//   out_row_last_o high with out_valid_o on the last element of each row
module result_drain_streamer #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int N      = systolic_pkg::N,
    parameter int ADDR_W = systolic_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_i,
    input  logic [N*N*DATA_W-1:0]      r_flat_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [DATA_W-1:0]   out_data_o,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic                       busy_o,
    output logic                       drain_done_o,
    output logic                       overrun_o,
`ifdef RESULT_DRAIN_LAST_EN
    output logic                       out_last_o,
    output logic                       out_row_last_o,
`endif
    input  logic                       overrun_clr_i
);

    import systolic_pkg::*;

    localparam int TILE   = N * N;
    localparam int IDX_W  = (TILE > 1) ? $clog2(TILE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE - 1);

    drain_state_e             state_q;
    logic [N*N*DATA_W-1:0]    snap_q;
    logic [ADDR_W-1:0]        base_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     drain_done_q;
    logic                     overrun_q;

    logic xfer;
    logic final_xfer;
    logic drop_done;

    assign xfer       = (state_q == DRAIN) && out_ready_i;
    assign final_xfer = xfer && (idx_q == LAST_IDX);
    // A done that lands on the final transfer starts the next tile instead
    // of being dropped, so only a done on any other DRAIN edge is lost.
    assign drop_done  = (state_q == DRAIN) && done_i && !final_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            drain_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            drain_done_q <= final_xfer;

            if (drop_done)
                overrun_q <= 1'b1;
            else if (overrun_clr_i)
                overrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (done_i) begin
                        snap_q  <= r_flat_i;
                        base_q  <= base_addr_i;
                        idx_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (final_xfer) begin
                        idx_q <= '0;
                        if (done_i) begin
                            snap_q <= r_flat_i;
                            base_q <= base_addr_i;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (xfer) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and address are forced to zero outside DRAIN so idle outputs are
    // quiet rather than showing a stale snapshot.
    assign out_valid_o  = (state_q == DRAIN);
    assign busy_o       = (state_q == DRAIN);
    assign out_data_o   = out_valid_o ? snap_q[DATA_W*idx_q +: DATA_W] : '0;
    assign out_addr_o   = out_valid_o ? (base_q + ADDR_W'(idx_q)) : '0;
    assign drain_done_o = drain_done_q;
    assign overrun_o    = overrun_q;

`ifdef RESULT_DRAIN_LAST_EN
    assign out_last_o     = out_valid_o && (idx_q == LAST_IDX);
    assign out_row_last_o = out_valid_o && ((32'(idx_q) % N) == (N - 1));
`endif

endmodule

// File: tb/tb_result_drain_streamer.sv
module tb_result_drain_streamer;
    import systolic_pkg::*;

    localparam int DW = 16;
    localparam int NN = 4;
    localparam int AW = 6;

    logic                   clk;
    logic                   rst;
    logic                   done_i;
    logic [NN*NN*DW-1:0]    r_flat_i;
    logic [AW-1:0]          base_addr_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic signed [DW-1:0]   out_data_o;
    logic [AW-1:0]          out_addr_o;
    logic                   busy_o;
    logic                   drain_done_o;
    logic                   overrun_o;
    logic                   overrun_clr_i;
`ifdef RESULT_DRAIN_LAST_EN
    logic                   out_last_o;
    logic                   out_row_last_o;
`endif

    int vectors;
    int miscompares;

    logic [NN*NN*DW-1:0] tile_pos;
    logic [NN*NN*DW-1:0] tile_neg;
    elem_t               exp_q[$];

    result_drain_streamer #(.DATA_W(DW), .N(NN), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .done_i         (done_i),
        .r_flat_i       (r_flat_i),
        .base_addr_i    (base_addr_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_addr_o     (out_addr_o),
        .busy_o         (busy_o),
        .drain_done_o   (drain_done_o),
        .overrun_o      (overrun_o),
`ifdef RESULT_DRAIN_LAST_EN
        .out_last_o     (out_last_o),
        .out_row_last_o (out_row_last_o),
`endif
        .overrun_clr_i  (overrun_clr_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element k (row-major, k = N*i+j) holds k+1 or -(k+1): values 1..16 / -1..-16.
    function automatic logic [NN*NN*DW-1:0] make_tile(input bit neg);
        logic [NN*NN*DW-1:0] t;
        t = '0;
        for (int k = 0; k < NN*NN; k++)
            t[DW*k +: DW] = neg ? DW'(-(k+1)) : DW'(k+1);
        return t;
    endfunction

    task automatic load_expected(input bit neg);
        exp_q.delete();
        for (int k = 0; k < NN*NN; k++)
            exp_q.push_back(neg ? elem_t'(-(k+1)) : elem_t'(k+1));
    endtask

    task automatic send_done(input logic [NN*NN*DW-1:0] tile, input logic [AW-1:0] base);
        r_flat_i    = tile;
        base_addr_i = base;
        done_i      = 1'b1;
        tick();
        done_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({out_valid_o, busy_o, drain_done_o, overrun_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=0000", {out_valid_o, busy_o, drain_done_o, overrun_o});
        end
        vectors++;
        if (out_data_o !== '0 || out_addr_o !== '0) begin
            miscompares++;
            $display("FAIL reset_data_addr got data=%0d addr=%0d exp 0/0", out_data_o, out_addr_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        elem_t e;
        load_expected(1'b0);
        out_ready_i = 1'b1;
        send_done(tile_pos, 6'd0);
        for (int k = 0; k < NN*NN; k++) begin
            e = exp_q.pop_front();
            vectors++;
            if (out_valid_o !== 1'b1 || busy_o !== 1'b1 || out_data_o !== e || out_addr_o !== AW'(k)
                || drain_done_o !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_xfer%0d got v=%b b=%b d=%0d a=%0d dd=%b exp v=1 b=1 d=%0d a=%0d dd=0",
                         k, out_valid_o, busy_o, out_data_o, out_addr_o, drain_done_o, e, k);
            end
`ifdef RESULT_DRAIN_LAST_EN
            vectors++;
            if (out_last_o !== (k == NN*NN-1) || out_row_last_o !== ((k % NN) == NN-1)) begin
                miscompares++;
                $display("FAIL basic_last%0d got last=%b row_last=%b exp %b %b",
                         k, out_last_o, out_row_last_o, (k == NN*NN-1), ((k % NN) == NN-1));
            end
`endif
            tick();
        end
        vectors++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || drain_done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_end got v=%b b=%b dd=%b exp v=0 b=0 dd=1", out_valid_o, busy_o, drain_done_o);
        end
        tick();
        vectors++;
        if (drain_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse got dd=%b exp 0", drain_done_o);
        end
    endtask

    task automatic test_stall();
        int cnt;
        int cyc;
        logic rdy;
        load_expected(1'b0);
        out_ready_i = 1'b1;
        send_done(tile_pos, 6'd0);
        cnt = 0;
        cyc = 0;
        // Every check expects element cnt; a stalled cycle must leave it unchanged.
        while (cnt < NN*NN && cyc < 100) begin
            vectors++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_q[cnt] || out_addr_o !== AW'(cnt)) begin
                miscompares++;
                $display("FAIL stall_cyc%0d got v=%b d=%0d a=%0d exp v=1 d=%0d a=%0d",
                         cyc, out_valid_o, out_data_o, out_addr_o, exp_q[cnt], cnt);
            end
            rdy = (cyc % 2 == 0);
            out_ready_i = rdy;
            tick();
            if (rdy) cnt++;
            cyc++;
        end
        out_ready_i = 1'b1;
        vectors++;
        if (cnt !== NN*NN || drain_done_o !== 1'b1 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_end got xfers=%0d dd=%b v=%b exp 16 1 0", cnt, drain_done_o, out_valid_o);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        load_expected(1'b0);
        out_ready_i = 1'b1;
        send_done(tile_pos, 6'd60);
        for (int k = 0; k < NN*NN; k++) begin
            ea = AW'((60 + k) % 64);
            vectors++;
            if (out_addr_o !== ea || out_data_o !== exp_q[k]) begin
                miscompares++;
                $display("FAIL wrap_xfer%0d got a=%0d d=%0d exp a=%0d d=%0d", k, out_addr_o, out_data_o, ea, exp_q[k]);
            end
            tick();
        end
        vectors++;
        if (drain_done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_done got dd=%b exp 1", drain_done_o);
        end
        tick();
    endtask

    task automatic test_overrun();
        load_expected(1'b0);
        out_ready_i = 1'b1;
        send_done(tile_pos, 6'd0);
        for (int k = 0; k < NN*NN; k++) begin
            vectors++;
            if (out_data_o !== exp_q[k] || out_addr_o !== AW'(k)) begin
                miscompares++;
                $display("FAIL overrun_xfer%0d got d=%0d a=%0d exp d=%0d a=%0d", k, out_data_o, out_addr_o, exp_q[k], k);
            end
            if (k == 4) begin
                r_flat_i = tile_neg;
                done_i   = 1'b1;
            end
            tick();
            done_i = 1'b0;
            if (k == 4) begin
                vectors++;
                if (overrun_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL overrun_set got=%b exp=1", overrun_o);
                end
            end
        end
        vectors++;
        if (overrun_o !== 1'b1 || drain_done_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_sticky got ov=%b dd=%b b=%b exp 1 1 0", overrun_o, drain_done_o, busy_o);
        end
        overrun_clr_i = 1'b1;
        tick();
        overrun_clr_i = 1'b0;
        vectors++;
        if (overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear got=%b exp=0", overrun_o);
        end
    endtask

    task automatic test_back_to_back();
        load_expected(1'b0);
        out_ready_i = 1'b1;
        send_done(tile_pos, 6'd0);
        for (int k = 0; k < NN*NN; k++) begin
            vectors++;
            if (out_data_o !== exp_q[k]) begin
                miscompares++;
                $display("FAIL b2b_first%0d got d=%0d exp %0d", k, out_data_o, exp_q[k]);
            end
            if (k == NN*NN-1) begin
                r_flat_i = tile_neg;
                done_i   = 1'b1;
            end
            tick();
            done_i = 1'b0;
        end
        vectors++;
        if (drain_done_o !== 1'b1 || busy_o !== 1'b1 || out_valid_o !== 1'b1 || overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_handover got dd=%b b=%b v=%b ov=%b exp 1 1 1 0",
                     drain_done_o, busy_o, out_valid_o, overrun_o);
        end
        load_expected(1'b1);
        for (int k = 0; k < NN*NN; k++) begin
            vectors++;
            if (out_data_o !== exp_q[k] || out_addr_o !== AW'(k)) begin
                miscompares++;
                $display("FAIL b2b_second%0d got d=%0d a=%0d exp d=%0d a=%0d", k, out_data_o, out_addr_o, exp_q[k], k);
            end
            tick();
        end
        vectors++;
        if (drain_done_o !== 1'b1 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end got dd=%b b=%b ov=%b exp 1 0 0", drain_done_o, busy_o, overrun_o);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        load_expected(1'b0);
        out_ready_i = 1'b1;
        send_done(tile_pos, 6'd0);
        for (int k = 0; k < 7; k++) tick();
        // Reset asserted on the edge of transfer 8.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({out_valid_o, busy_o, drain_done_o, overrun_o} !== 4'b0000 || out_data_o !== '0 || out_addr_o !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs got v=%b b=%b dd=%b ov=%b d=%0d a=%0d exp all 0",
                     out_valid_o, busy_o, drain_done_o, overrun_o, out_data_o, out_addr_o);
        end
        tick();
        load_expected(1'b1);
        send_done(tile_neg, 6'd5);
        vectors++;
        if (out_valid_o !== 1'b1 || out_data_o !== exp_q[0] || out_addr_o !== 6'd5) begin
            miscompares++;
            $display("FAIL midrst_restart got v=%b d=%0d a=%0d exp v=1 d=%0d a=5", out_valid_o, out_data_o, out_addr_o, exp_q[0]);
        end
        for (int k = 0; k < NN*NN; k++) tick();
        vectors++;
        if (drain_done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_done got dd=%b exp 1", drain_done_o);
        end
        tick();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        tile_pos      = make_tile(1'b0);
        tile_neg      = make_tile(1'b1);
        rst           = 1'b1;
        done_i        = 1'b0;
        r_flat_i      = '0;
        base_addr_i   = '0;
        out_ready_i   = 1'b0;
        overrun_clr_i = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_overrun();
        test_back_to_back();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
